// File: rtl/game_screen_sequencer.sv
// game_screen_sequencer: frame-synchronous start/countdown/play/end screen controller.
// Optional pause support is built when GAME_PAUSE_EN is defined.
module game_screen_sequencer #(
    parameter int HEALTH_W         = 8,
    parameter int COUNTDOWN_FRAMES = 180,
    parameter int END_HOLD_FRAMES  = 120
) (
    input  logic                clk_in,
    input  logic                rst_n_in,
    input  logic                new_frame_in,
    input  logic                start_btn_in,
`ifdef GAME_PAUSE_EN
    input  logic                pause_btn_in,
`endif
    input  logic [HEALTH_W-1:0] player_health_in,
    input  logic [HEALTH_W-1:0] opponent_health_in,
    output logic                start_display_out,
    output logic                end_win_out,
    output logic                end_lose_out,
    output logic                game_active_out,
    output logic [1:0]          countdown_out,
    output logic [2:0]          state_out
);
    localparam int MAXF = (COUNTDOWN_FRAMES > END_HOLD_FRAMES) ? COUNTDOWN_FRAMES : END_HOLD_FRAMES;
    localparam int CW   = $clog2(MAXF + 1);
    localparam logic [CW-1:0] CD_LAST = CW'(COUNTDOWN_FRAMES - 1);
    localparam logic [CW-1:0] HOLD    = CW'(END_HOLD_FRAMES);
    localparam logic [CW-1:0] T3      = CW'(COUNTDOWN_FRAMES / 3);
    localparam logic [CW-1:0] T2      = CW'(2 * COUNTDOWN_FRAMES / 3);

    typedef enum logic [2:0] {
        IDLE = 3'd0, COUNTDOWN = 3'd1, PLAY = 3'd2, WIN = 3'd3, LOSE = 3'd4, PAUSE = 3'd5
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            start_prev_q, start_lat_q, start_lat_d, start_ev;
    logic            pause_ev;
    logic            sd_q, sd_d, win_q, win_d, lose_q, lose_d, act_q, act_d;
    logic [1:0]      cd_q, cd_d;

    // A press arriving in the boundary cycle itself still counts for that frame.
    assign start_ev    = start_lat_q | (start_btn_in & ~start_prev_q);
    assign start_lat_d = new_frame_in ? 1'b0 : start_ev;

`ifdef GAME_PAUSE_EN
    logic pause_prev_q, pause_lat_q;
    assign pause_ev = pause_lat_q | (pause_btn_in & ~pause_prev_q);
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            pause_prev_q <= 1'b0;
            pause_lat_q  <= 1'b0;
        end else begin
            pause_prev_q <= pause_btn_in;
            pause_lat_q  <= new_frame_in ? 1'b0 : pause_ev;
        end
    end
`else
    assign pause_ev = 1'b0;
`endif

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            start_prev_q <= 1'b0;
            start_lat_q  <= 1'b0;
            sd_q         <= 1'b1;
            win_q        <= 1'b0;
            lose_q       <= 1'b0;
            act_q        <= 1'b0;
            cd_q         <= 2'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            start_prev_q <= start_btn_in;
            start_lat_q  <= start_lat_d;
            sd_q         <= sd_d;
            win_q        <= win_d;
            lose_q       <= lose_d;
            act_q        <= act_d;
            cd_q         <= cd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (new_frame_in) begin
            case (state_q)
                IDLE: if (start_ev) begin
                    state_d = COUNTDOWN;
                    cnt_d   = '0;
                end
                COUNTDOWN: begin
                    state_d = (cnt_q == CD_LAST) ? PLAY : COUNTDOWN;
                    cnt_d   = (cnt_q == CD_LAST) ? '0 : cnt_q + 1'b1;
                end
                PLAY: if (pause_ev) begin
                    state_d = PAUSE;
                end else if (player_health_in == '0) begin
                    state_d = LOSE;
                    cnt_d   = '0;
                end else if (opponent_health_in == '0) begin
                    state_d = WIN;
                    cnt_d   = '0;
                end
                WIN, LOSE: begin
                    // Presses before the hold expires are dropped by the latch clear.
                    state_d = (start_ev && cnt_q == HOLD) ? IDLE : state_q;
                    cnt_d   = (cnt_q == HOLD) ? cnt_q : cnt_q + 1'b1;
                end
                PAUSE: state_d = start_ev ? IDLE : (pause_ev ? PLAY : PAUSE);
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        sd_d   = state_d == IDLE;
        win_d  = state_d == WIN;
        lose_d = state_d == LOSE;
        act_d  = state_d == PLAY;
        cd_d   = (state_d != COUNTDOWN) ? 2'd0 : (cnt_d < T3) ? 2'd3 : (cnt_d < T2) ? 2'd2 : 2'd1;
    end

    assign start_display_out = sd_q;
    assign end_win_out       = win_q;
    assign end_lose_out      = lose_q;
    assign game_active_out   = act_q;
    assign countdown_out     = cd_q;
    assign state_out         = state_q;
endmodule

// File: tb/tb_game_screen_sequencer.sv
// tb_game_screen_sequencer: directed self-checking bench for game_screen_sequencer.
module tb_game_screen_sequencer;
    logic       clk_in = 1'b0, rst_n_in = 1'b0, new_frame_in = 1'b0, start_btn_in = 1'b0;
    logic [7:0] player_health_in = 8'h40, opponent_health_in = 8'h40;
`ifdef GAME_PAUSE_EN
    logic       pause_btn_in = 1'b0;
`endif
    logic       start_display_out, end_win_out, end_lose_out, game_active_out;
    logic [1:0] countdown_out;
    logic [2:0] state_out;
    int         errs = 0, checks = 0;

    game_screen_sequencer #(.HEALTH_W(8), .COUNTDOWN_FRAMES(6), .END_HOLD_FRAMES(4)) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .new_frame_in(new_frame_in),
        .start_btn_in(start_btn_in),
`ifdef GAME_PAUSE_EN
        .pause_btn_in(pause_btn_in),
`endif
        .player_health_in(player_health_in), .opponent_health_in(opponent_health_in),
        .start_display_out(start_display_out), .end_win_out(end_win_out),
        .end_lose_out(end_lose_out), .game_active_out(game_active_out),
        .countdown_out(countdown_out), .state_out(state_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errs++;
            $display("FAIL %s: got=%03h exp=%03h", tag, got, exp);
        end
    endtask

    // Packs {state, start, win, lose, active, countdown} for a single comparison.
    task automatic expect_out(input string tag, input int st, input int sd, input int w,
                              input int l, input int a, input int cd);
        check(tag, int'({state_out, start_display_out, end_win_out, end_lose_out,
                         game_active_out, countdown_out}),
              st * 64 + sd * 32 + w * 16 + l * 8 + a * 4 + cd);
    endtask

    task automatic frame(input bit with_press = 1'b0);
        @(negedge clk_in);
        new_frame_in = 1'b1;
        start_btn_in = with_press;
        @(negedge clk_in);
        new_frame_in = 1'b0;
        start_btn_in = 1'b0;
        repeat (2) @(negedge clk_in);
    endtask

    task automatic press();
        @(negedge clk_in);
        start_btn_in = 1'b1;
        @(negedge clk_in);
        start_btn_in = 1'b0;
    endtask

`ifdef GAME_PAUSE_EN
    task automatic pause_press();
        @(negedge clk_in);
        pause_btn_in = 1'b1;
        @(negedge clk_in);
        pause_btn_in = 1'b0;
    endtask
`endif

    task automatic to_play();
        int cd_exp[5] = '{3, 2, 2, 1, 1};
        frame(1'b1);
        expect_out("cd_enter", 1, 0, 0, 0, 0, 3);
        for (int i = 0; i < 5; i++) begin
            frame();
            expect_out($sformatf("cd_%0d", i + 1), 1, 0, 0, 0, 0, cd_exp[i]);
        end
        frame();
        expect_out("play_enter", 2, 0, 0, 0, 1, 0);
    endtask

    initial begin
        repeat (2) @(negedge clk_in);
        expect_out("reset", 0, 1, 0, 0, 0, 0);
        rst_n_in = 1'b1;
        for (int i = 0; i < 10; i++) begin
            frame();
            expect_out($sformatf("idle_%0d", i), 0, 1, 0, 0, 0, 0);
        end
        press();
        repeat (3) @(negedge clk_in);
        expect_out("press_midframe", 0, 1, 0, 0, 0, 0);
        frame();
        expect_out("cd_latched", 1, 0, 0, 0, 0, 3);
        begin
            int cd_exp[5] = '{3, 2, 2, 1, 1};
            for (int i = 0; i < 5; i++) begin
                frame();
                expect_out($sformatf("cd_seq_%0d", i + 1), 1, 0, 0, 0, 0, cd_exp[i]);
            end
        end
        frame();
        expect_out("play", 2, 0, 0, 0, 1, 0);
        player_health_in = 8'h40;
        opponent_health_in = 8'h05;
        frame();
        expect_out("play_alive", 2, 0, 0, 0, 1, 0);
        opponent_health_in = 8'h00;
        repeat (3) @(negedge clk_in);
        expect_out("health_midframe", 2, 0, 0, 0, 1, 0);
        frame();
        expect_out("win", 3, 0, 1, 0, 0, 0);
        frame();
        frame();
        press();
        frame();
        expect_out("early_press", 3, 0, 1, 0, 0, 0);
        player_health_in = 8'h00;
        frame();
        expect_out("win_health0", 3, 0, 1, 0, 0, 0);
        frame();
        expect_out("no_queue", 3, 0, 1, 0, 0, 0);
        press();
        frame();
        expect_out("win_release", 0, 1, 0, 0, 0, 0);

        player_health_in = 8'h40;
        opponent_health_in = 8'h40;
        to_play();
        player_health_in = 8'h00;
        frame();
        expect_out("lose", 4, 0, 0, 1, 0, 0);
        repeat (4) frame();
        press();
        frame();
        expect_out("lose_release", 0, 1, 0, 0, 0, 0);

        player_health_in = 8'h20;
        opponent_health_in = 8'h20;
        to_play();
        player_health_in = 8'h00;
        opponent_health_in = 8'h00;
        frame();
        expect_out("tie_lose", 4, 0, 0, 1, 0, 0);

        player_health_in = 8'h20;
        opponent_health_in = 8'h20;
        repeat (4) frame();
        press();
        frame();
        to_play();
        @(negedge clk_in);
        #2 rst_n_in = 1'b0;
        #1 expect_out("async_rst", 0, 1, 0, 0, 0, 0);
        @(negedge clk_in);
        rst_n_in = 1'b1;

`ifdef GAME_PAUSE_EN
        to_play();
        pause_press();
        frame();
        expect_out("pause", 5, 0, 0, 0, 0, 0);
        player_health_in = 8'h00;
        frame();
        expect_out("pause_health", 5, 0, 0, 0, 0, 0);
        pause_press();
        frame();
        expect_out("unpause", 2, 0, 0, 0, 1, 0);
        frame();
        expect_out("pause_lose", 4, 0, 0, 1, 0, 0);
        rst_n_in = 1'b0;
        @(negedge clk_in);
        rst_n_in = 1'b1;
        player_health_in = 8'h20;
        to_play();
        pause_press();
        frame();
        expect_out("pause2", 5, 0, 0, 0, 0, 0);
        press();
        frame();
        expect_out("pause_start", 0, 1, 0, 0, 0, 0);
`endif
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/game_screen_sequencer.md
Name: game_screen_sequencer

Overview:
- Frame-synchronous game-flow controller that drives the screen-select and layer-enable inputs of the display pixel mux.
- Sequences start screen -> countdown -> play -> win/lose screen -> start screen from the start button and the two health values.
- All outputs are registered and change only at frame boundaries, so the mux never switches screens mid-frame (no tearing).

Parameters:
HEALTH_W, 8, width of player/opponent health inputs
COUNTDOWN_FRAMES, 180, frames spent in COUNTDOWN (3 s at 60 Hz); must be >= 3
END_HOLD_FRAMES, 120, minimum frames the win/lose screen is shown before a press is accepted

Ports:
clk_in  input  1  pixel clock
rst_n_in  input  1  asynchronous reset, active-low
new_frame_in  input  1  one-cycle pulse at the first pixel of each frame
start_btn_in  input  1  debounced start button level, synchronous to clk_in
player_health_in  input  HEALTH_W  current player health; 0 = dead
opponent_health_in  input  HEALTH_W  current opponent health; 0 = dead
start_display_out  output  1  select start screen layer
end_win_out  output  1  select win screen layer
end_lose_out  output  1  select lose screen layer
game_active_out  output  1  enables saber/box/health/line layers and hit processing
countdown_out  output  2  countdown digit 3/2/1 during COUNTDOWN; 0 otherwise
state_out  output  3  encoded state for debug LEDs: IDLE=0 COUNTDOWN=1 PLAY=2 WIN=3 LOSE=4 PAUSE=5

Behaviour:
- Reset (rst_n_in low, asynchronous): state IDLE, frame counter 0, press latch 0, start_display_out=1, all other outputs 0, state_out=0. Reset mid-game abandons the game immediately, with no frame wait.
- Press detect: rising edge of start_btn_in (registered previous level) sets a press latch. The latch is cleared at every new_frame_in and ignored unless the state consumes it at that boundary. A press and new_frame_in in the same cycle count for that frame.
- State evaluation happens only in cycles where new_frame_in=1. Outputs update from the new state on the next clock edge, so latency is 1 cycle after the boundary.
- IDLE: start_display_out=1. A latched press moves to COUNTDOWN and clears the frame counter.
- COUNTDOWN: the frame counter increments each boundary.
  - countdown_out=3 while count < COUNTDOWN_FRAMES/3, 2 while count < 2*COUNTDOWN_FRAMES/3, otherwise 1 (integer division).
  - At count == COUNTDOWN_FRAMES-1, move to PLAY and clear the counter.
  - start_display_out=0. game_active_out=0.
- PLAY: game_active_out=1. Healths are sampled at the boundary.
  - Both 0: LOSE (a tie is a loss).
  - player==0 only: LOSE.
  - opponent==0 only: WIN.
  - Entering WIN or LOSE clears the counter.
- WIN or LOSE: end_win_out=1 or end_lose_out=1 respectively. game_active_out=0.
  - The counter increments, saturating at END_HOLD_FRAMES.
  - A latched press is accepted only when counter == END_HOLD_FRAMES, and moves to IDLE. Earlier presses are discarded, not queued.
- Exactly one of start_display_out/end_win_out/end_lose_out/game_active_out is 1 in IDLE, WIN, LOSE and PLAY. All four are 0 in COUNTDOWN and PAUSE.
- Counter width is $clog2(max(COUNTDOWN_FRAMES, END_HOLD_FRAMES)+1). It never wraps.
- Health inputs are ignored outside PLAY. Healths returning nonzero after WIN/LOSE do not change state.

Optional Feature:
- Macro: GAME_PAUSE_EN.
- Defined:
  - Adds input pause_btn_in (1 bit, debounced) with its own rising-edge latch, same latch rules as the start press.
  - In PLAY, a latched pause moves to PAUSE (state_out=5, all layer selects 0, countdown_out=0). Healths are not evaluated that frame.
  - In PAUSE, a latched pause returns to PLAY. A latched start press in PAUSE goes to IDLE.
  - If start and pause presses are latched in the same frame, pause takes priority in PLAY and start takes priority in PAUSE.
- Undefined: no pause port, PAUSE is unreachable, and state_out never equals 5.

Test Plan:
- Reset, then release with no press for 10 frames -> state_out=0, start_display_out=1, others 0 throughout. Assert rst_n_in low mid-PLAY -> same values within the same cycle (asynchronous).
- COUNTDOWN_FRAMES=6: press in IDLE -> state 1 one cycle after the next new_frame_in. countdown_out sequence per frame is 3,3,2,2,1,1, then state 2 and game_active_out=1.
- In PLAY, opponent_health 0x05->0x00 with player_health 0x40 -> WIN (end_win_out=1) one cycle after the next boundary. Repeat with player=0 -> LOSE. Repeat with both 0 -> LOSE.
- END_HOLD_FRAMES=4 in WIN: press at hold frame 2 -> stays WIN. Press after 4 frames -> IDLE at the following boundary. Dropping health to 0 while in WIN -> no change.
- Toggle start_btn_in and health mid-frame (no new_frame_in) -> no output change until the boundary. Press coincident with new_frame_in -> accepted that frame.
- With GAME_PAUSE_EN: pause in PLAY -> state 5 with all selects 0. Health 0 during PAUSE -> ignored. Pause again -> PLAY, then health 0 -> LOSE. Start press in PAUSE -> IDLE.
